// File: rtl/cache_arb_pkg.sv
// Shared types for the cache memory arbiter: read FSM states, grant encoding, line offset width.
package cache_arb_pkg;

    localparam int LINE_OFF_W = 4;

    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_REQ  = 3'b010,
        R_RET  = 3'b100
    } r_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

endpackage

// File: rtl/cache_wr_buf.sv
// One-entry dcache writeback buffer: captures a victim line when empty, drains it downstream.
// Exposes the buffered line address so reads can be held off until the line has left.
module cache_wr_buf
    import cache_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_req,
    input  logic [2:0]                 wr_type,
    input  logic [DATA_W-1:0]          wr_addr,
    input  logic [DATA_W/8-1:0]        wr_wstrb,
    input  logic [LINE_W-1:0]          wr_data,
    output logic                       wr_rdy,
    output logic                       m_wr_req,
    output logic [2:0]                 m_wr_type,
    output logic [DATA_W-1:0]          m_wr_addr,
    output logic [DATA_W/8-1:0]        m_wr_wstrb,
    output logic [LINE_W-1:0]          m_wr_data,
    input  logic                       m_wr_rdy,
    output logic                       buf_valid,
    output logic [DATA_W-LINE_OFF_W-1:0] buf_line_addr
);

    logic                  valid_reg;
    logic [2:0]            type_reg;
    logic [DATA_W-1:0]     addr_reg;
    logic [DATA_W/8-1:0]   wstrb_reg;
    logic [LINE_W-1:0]     data_reg;
    logic                  capture;

    // Capture only when empty, so a capture and a drain never coincide.
    assign capture = wr_req && !valid_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else if (capture) begin
            valid_reg <= 1'b1;
        end else if (valid_reg && m_wr_rdy) begin
            valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            type_reg  <= wr_type;
            addr_reg  <= wr_addr;
            wstrb_reg <= wr_wstrb;
            data_reg  <= wr_data;
        end
    end

    assign wr_rdy        = !valid_reg;
    assign m_wr_req      = valid_reg;
    assign m_wr_type     = type_reg;
    assign m_wr_addr     = addr_reg;
    assign m_wr_wstrb    = wstrb_reg;
    assign m_wr_data     = data_reg;
    assign buf_valid     = valid_reg;
    assign buf_line_addr = addr_reg[DATA_W-1:LINE_OFF_W];

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one cache-line memory port between icache and dcache: serialised 4-beat refills plus a
// one-entry writeback buffer. Define ARB_RR_EN for round-robin tie-breaking (default: dcache wins).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rd_req,
    input  logic [2:0]           i_rd_type,
    input  logic [DATA_W-1:0]    i_rd_addr,
    output logic                 i_rd_rdy,
    output logic                 i_ret_valid,
    output logic                 i_ret_last,
    input  logic                 d_rd_req,
    input  logic [2:0]           d_rd_type,
    input  logic [DATA_W-1:0]    d_rd_addr,
    output logic                 d_rd_rdy,
    output logic                 d_ret_valid,
    output logic                 d_ret_last,
    output logic [DATA_W-1:0]    ret_data,
    input  logic                 d_wr_req,
    input  logic [2:0]           d_wr_type,
    input  logic [DATA_W-1:0]    d_wr_addr,
    input  logic [DATA_W/8-1:0]  d_wr_wstrb,
    input  logic [LINE_W-1:0]    d_wr_data,
    output logic                 d_wr_rdy,
    output logic                 m_rd_req,
    output logic [2:0]           m_rd_type,
    output logic [DATA_W-1:0]    m_rd_addr,
    input  logic                 m_rd_rdy,
    input  logic                 m_ret_valid,
    input  logic                 m_ret_last,
    input  logic [DATA_W-1:0]    m_ret_data,
    output logic                 m_wr_req,
    output logic [2:0]           m_wr_type,
    output logic [DATA_W-1:0]    m_wr_addr,
    output logic [DATA_W/8-1:0]  m_wr_wstrb,
    output logic [LINE_W-1:0]    m_wr_data,
    input  logic                 m_wr_rdy
);

    r_state_e                    state_reg, state_next;
    gnt_e                        grant_reg, grant_next;
    logic [DATA_W-1:0]           addr_reg, addr_next;
    logic [2:0]                  type_reg, type_next;
    logic                        buf_valid;
    logic [DATA_W-LINE_OFF_W-1:0] buf_line_addr;
    logic                        d_elig;
    logic                        pick_d;
    logic [1:0]                  gnt_onehot;
    logic [1:0]                  rd_rdy_vec, ret_valid_vec, ret_last_vec;

    cache_wr_buf #(
        .DATA_W (DATA_W),
        .LINE_W (LINE_W)
    ) u_wr_buf (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (d_wr_req),
        .wr_type       (d_wr_type),
        .wr_addr       (d_wr_addr),
        .wr_wstrb      (d_wr_wstrb),
        .wr_data       (d_wr_data),
        .wr_rdy        (d_wr_rdy),
        .m_wr_req      (m_wr_req),
        .m_wr_type     (m_wr_type),
        .m_wr_addr     (m_wr_addr),
        .m_wr_wstrb    (m_wr_wstrb),
        .m_wr_data     (m_wr_data),
        .m_wr_rdy      (m_wr_rdy),
        .buf_valid     (buf_valid),
        .buf_line_addr (buf_line_addr)
    );

    // A dcache refill of the line still sitting in the write buffer would read stale memory.
    assign d_elig = d_rd_req && !(buf_valid && (d_rd_addr[DATA_W-1:LINE_OFF_W] == buf_line_addr));

`ifdef ARB_RR_EN
    gnt_e last_grant_reg;

    assign pick_d = d_elig && (!i_rd_req || (last_grant_reg == GNT_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= GNT_I;
        end else if ((state_reg == R_IDLE) && (state_next == R_REQ)) begin
            last_grant_reg <= grant_next;
        end
    end
`else
    assign pick_d = d_elig;
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        addr_next  = addr_reg;
        type_next  = type_reg;
        case (state_reg)
            R_IDLE: begin
                if (i_rd_req || d_elig) begin
                    state_next = R_REQ;
                    grant_next = pick_d ? GNT_D : GNT_I;
                    addr_next  = pick_d ? d_rd_addr : i_rd_addr;
                    type_next  = pick_d ? d_rd_type : i_rd_type;
                end
            end
            R_REQ: begin
                if (m_rd_rdy) begin
                    state_next = R_RET;
                end
            end
            R_RET: begin
                if (m_ret_valid && m_ret_last) begin
                    state_next = R_IDLE;
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= R_IDLE;
            grant_reg <= GNT_D;
            addr_reg  <= '0;
            type_reg  <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            addr_reg  <= addr_next;
            type_reg  <= type_next;
        end
    end

    assign m_rd_req   = (state_reg == R_REQ);
    assign m_rd_addr  = addr_reg;
    assign m_rd_type  = type_reg;
    assign ret_data   = m_ret_data;

    // Index 0 is the icache, index 1 the dcache, matching the gnt_e encoding.
    assign gnt_onehot = {grant_reg == GNT_D, grant_reg == GNT_I};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign rd_rdy_vec[gi]    = gnt_onehot[gi] && (state_reg == R_REQ) && m_rd_rdy;
            assign ret_valid_vec[gi] = gnt_onehot[gi] && (state_reg == R_RET) && m_ret_valid;
            assign ret_last_vec[gi]  = gnt_onehot[gi] && (state_reg == R_RET) && m_ret_valid && m_ret_last;
        end
    endgenerate

    assign i_rd_rdy    = rd_rdy_vec[0];
    assign d_rd_rdy    = rd_rdy_vec[1];
    assign i_ret_valid = ret_valid_vec[0];
    assign d_ret_valid = ret_valid_vec[1];
    assign i_ret_last  = ret_last_vec[0];
    assign d_ret_last  = ret_last_vec[1];

endmodule
